// File: rtl/if_fetch_sequencer.sv
// Instruction-fetch front end: PC/nPC pair, IF/ID pipeline register and a fetch counter.
// Implements SPARC delayed control transfer, where a taken CTI redirects after its delay slot.
module if_fetch_sequencer #(
   parameter int unsigned ADDR_W   = 8,
   parameter logic [31:0] NOP_WORD = 32'h0100_0000
) (
   input  logic              Clk,
   input  logic              R,
   input  logic              LE,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_data,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] target,
   input  logic              annul,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] npc,
   output logic [31:0]       ifid_instr,
   output logic [ADDR_W-1:0] ifid_pc,
   output logic              ifid_valid,
   output logic [15:0]       fetch_count
);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] npc_q, npc_d;
   logic [31:0]       ifid_instr_q, ifid_instr_d;
   logic [ADDR_W-1:0] ifid_pc_q, ifid_pc_d;
   logic              ifid_valid_q, ifid_valid_d;
   logic [15:0]       fetch_count_q, fetch_count_d;
   logic [ADDR_W-1:0] target_aligned;

   assign target_aligned = {target[ADDR_W-1:2], 2'b00};

   always_comb begin
      pc_d          = pc_q;
      npc_d         = npc_q;
      ifid_instr_d  = ifid_instr_q;
      ifid_pc_d     = ifid_pc_q;
      ifid_valid_d  = ifid_valid_q;
      fetch_count_d = fetch_count_q;
      if (LE) begin
         // The slot at pc is always consumed; annul only turns it into a bubble.
         pc_d      = redirect ? target_aligned : npc_q;
         npc_d     = pc_d + ADDR_W'(4);
         ifid_pc_d = pc_q;
         if (annul) begin
            ifid_instr_d = NOP_WORD;
            ifid_valid_d = 1'b0;
         end else begin
            ifid_instr_d = imem_data;
            ifid_valid_d = 1'b1;
            if (fetch_count_q != 16'hFFFF) begin
               fetch_count_d = fetch_count_q + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge R) begin
      if (!R) begin
         pc_q          <= '0;
         npc_q         <= ADDR_W'(4);
         ifid_instr_q  <= NOP_WORD;
         ifid_pc_q     <= '0;
         ifid_valid_q  <= 1'b0;
         fetch_count_q <= '0;
      end else begin
         pc_q          <= pc_d;
         npc_q         <= npc_d;
         ifid_instr_q  <= ifid_instr_d;
         ifid_pc_q     <= ifid_pc_d;
         ifid_valid_q  <= ifid_valid_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign npc         = npc_q;
   assign ifid_instr  = ifid_instr_q;
   assign ifid_pc     = ifid_pc_q;
   assign ifid_valid  = ifid_valid_q;
   assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_fetch_sequencer.sv
// Directed bench for if_fetch_sequencer: reset, sequential fetch, stall, redirect, annul,
// back-to-back redirects, address wrap and asynchronous reset between edges.
module tb_if_fetch_sequencer;

   localparam logic [31:0] Nop = 32'h0100_0000;

   logic        Clk;
   logic        R;
   logic        LE;
   logic [7:0]  imem_addr;
   logic [31:0] imem_data;
   logic        redirect;
   logic [7:0]  target;
   logic        annul;
   logic [7:0]  pc;
   logic [7:0]  npc;
   logic [31:0] ifid_instr;
   logic [7:0]  ifid_pc;
   logic        ifid_valid;
   logic [15:0] fetch_count;

   int unsigned n_checks;
   int unsigned n_fail;

   if_fetch_sequencer #(
      .ADDR_W  (8),
      .NOP_WORD(32'h0100_0000)
   ) u_dut (
      .Clk        (Clk),
      .R          (R),
      .LE         (LE),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .redirect   (redirect),
      .target     (target),
      .annul      (annul),
      .pc         (pc),
      .npc        (npc),
      .ifid_instr (ifid_instr),
      .ifid_pc    (ifid_pc),
      .ifid_valid (ifid_valid),
      .fetch_count(fetch_count)
   );

   // Word at 0 is fixed; every other address returns a tagged word so its origin is visible.
   function automatic logic [31:0] mem_word(input logic [7:0] a);
      if (a == 8'h00) return 32'h8200_6001;
      return 32'hC0DE_0000 | {24'h0, a};
   endfunction

   assign imem_data = mem_word(imem_addr);

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check_state(input string tag, input logic [7:0] e_pc, input logic [7:0] e_npc,
                              input logic [7:0] e_ifid_pc, input logic e_valid,
                              input logic [31:0] e_instr, input logic [15:0] e_cnt);
      check_eq({tag, ".pc"}, {24'h0, pc}, {24'h0, e_pc});
      check_eq({tag, ".imem_addr"}, {24'h0, imem_addr}, {24'h0, e_pc});
      check_eq({tag, ".npc"}, {24'h0, npc}, {24'h0, e_npc});
      check_eq({tag, ".ifid_pc"}, {24'h0, ifid_pc}, {24'h0, e_ifid_pc});
      check_eq({tag, ".valid"}, {31'h0, ifid_valid}, {31'h0, e_valid});
      check_eq({tag, ".instr"}, ifid_instr, e_instr);
      check_eq({tag, ".count"}, {16'h0, fetch_count}, {16'h0, e_cnt});
   endtask

   task automatic pulse_reset();
      #2 R = 1'b0;
      #1 check_state("async_rst", 8'h00, 8'h04, 8'h00, 1'b0, Nop, 16'd0);
      R = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      R        = 1'b0;
      LE       = 1'b1;
      redirect = 1'b0;
      annul    = 1'b0;
      target   = 8'h00;

      #12 check_state("reset", 8'h00, 8'h04, 8'h00, 1'b0, Nop, 16'd0);
      R = 1'b1;
      tick(); check_state("e1", 8'h04, 8'h08, 8'h00, 1'b1, 32'h8200_6001, 16'd1);
      tick(); check_state("e2", 8'h08, 8'h0C, 8'h04, 1'b1, 32'hC0DE_0004, 16'd2);
      tick(); check_state("e3", 8'h0C, 8'h10, 8'h08, 1'b1, 32'hC0DE_0008, 16'd3);

      // Stall: redirect/annul must be ignored.
      LE = 1'b0; redirect = 1'b1; annul = 1'b1; target = 8'h41;
      tick(); check_state("stall1", 8'h0C, 8'h10, 8'h08, 1'b1, 32'hC0DE_0008, 16'd3);
      tick(); check_state("stall2", 8'h0C, 8'h10, 8'h08, 1'b1, 32'hC0DE_0008, 16'd3);

      LE = 1'b1; annul = 1'b0;
      tick(); check_state("redir", 8'h40, 8'h44, 8'h0C, 1'b1, 32'hC0DE_000C, 16'd4);
      redirect = 1'b0;
      tick(); check_state("redir_tgt", 8'h44, 8'h48, 8'h40, 1'b1, 32'hC0DE_0040, 16'd5);

      pulse_reset();
      tick(); tick(); tick();
      check_state("restart", 8'h0C, 8'h10, 8'h08, 1'b1, 32'hC0DE_0008, 16'd3);

      redirect = 1'b1; annul = 1'b1; target = 8'h41;
      tick(); check_state("annul_redir", 8'h40, 8'h44, 8'h0C, 1'b0, Nop, 16'd3);
      redirect = 1'b0; annul = 1'b0;
      tick(); check_state("annul_tgt", 8'h44, 8'h48, 8'h40, 1'b1, 32'hC0DE_0040, 16'd4);

      pulse_reset();
      tick(); tick(); tick();
      annul = 1'b1;
      tick(); check_state("annul_untaken", 8'h10, 8'h14, 8'h0C, 1'b0, Nop, 16'd3);
      annul = 1'b0;

      // CTI in a delay slot: each edge uses its own target.
      redirect = 1'b1; target = 8'h80;
      tick(); check_state("b2b_1", 8'h80, 8'h84, 8'h10, 1'b1, 32'hC0DE_0010, 16'd4);
      target = 8'h22;
      tick(); check_state("b2b_2", 8'h20, 8'h24, 8'h80, 1'b1, 32'hC0DE_0080, 16'd5);

      target = 8'hF8;
      tick(); check_state("wrap0", 8'hF8, 8'hFC, 8'h20, 1'b1, 32'hC0DE_0020, 16'd6);
      redirect = 1'b0;
      tick(); check_state("wrap1", 8'hFC, 8'h00, 8'hF8, 1'b1, 32'hC0DE_00F8, 16'd7);
      tick(); check_state("wrap2", 8'h00, 8'h04, 8'hFC, 1'b1, 32'hC0DE_00FC, 16'd8);
      tick(); check_state("wrap3", 8'h04, 8'h08, 8'h00, 1'b1, 32'h8200_6001, 16'd9);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/if_fetch_sequencer.md
# if_fetch_sequencer

Instruction-fetch front end for the pipelined SPARC-subset datapath. It owns the PC/nPC pair and drives the instruction memory address. It also implements the IF/ID pipeline register, which feeds the ID-stage control unit. It applies SPARC delayed-control-transfer semantics: on a taken CTI the delay slot still executes, and the annul bit squashes that delay slot. Stall (LE), taken-CTI redirect and annul requests come back from the ID stage.

## Interface
- ADDR_W, 8, PC/nPC/instruction-memory byte-address width
- NOP_WORD, 32'h0100_0000, instruction (sethi 0,%g0) inserted into IF/ID when a slot is annulled
- Clk  input  1  pipeline clock, all state on rising edge
- R  input  1  reset, asynchronous, active-low (0 = reset)
- LE  input  1  load enable; 0 = stall, all state holds
- imem_addr  output  ADDR_W  fetch address to instruction memory, equals pc
- imem_data  input  32  instruction word returned combinationally for imem_addr
- redirect  input  1  ID stage: instruction in IF/ID is a taken CTI (branch taken, call, jmpl)
- target  input  ADDR_W  CTI target address, valid with redirect
- annul  input  1  ID stage: squash the delay-slot instruction currently being fetched
- pc  output  ADDR_W  current PC register
- npc  output  ADDR_W  current nPC register
- ifid_instr  output  32  IF/ID instruction to control unit / register file
- ifid_pc  output  ADDR_W  address of ifid_instr (used by call for r15 link)
- ifid_valid  output  1  1 = ifid_instr is a real instruction, 0 = bubble/annulled
- fetch_count  output  16  count of valid instructions delivered into IF/ID

## Operation
- Reset (R=0, asynchronous): pc=0, npc=4, ifid_instr=NOP_WORD, ifid_pc=0, ifid_valid=0, fetch_count=0. Reset dominates every other input.
- LE=0: pc, npc, IF/ID and fetch_count all hold. redirect and annul are ignored; the ID stage holds too and re-presents them.
- Normal edge (LE=1, redirect=0, annul=0):
  - ifid_instr<=imem_data, ifid_pc<=pc, ifid_valid<=1.
  - pc<=npc, npc<=npc+4.
- Redirect edge (LE=1, redirect=1):
  - The slot being fetched at pc is the delay slot. It is latched into IF/ID as normal unless annul=1.
  - pc<=target, npc<=target+4.
  - target[1:0] is forced to 00 before use.
- Annul edge (LE=1, annul=1):
  - ifid_instr<=NOP_WORD, ifid_valid<=0, ifid_pc<=pc.
  - PC update follows the redirect value: target if redirect=1, else npc.
  - Annul with redirect=0 is the untaken branch with a=1.
- fetch_count increments by 1 on every LE=1 edge that loads ifid_valid=1. It saturates at 16'hFFFF.
- Arithmetic: all address adds are modulo 2^ADDR_W, so 0xFC+4 wraps to 0x00 with no flag.
- No internal FSM beyond the registers. The sole state is pc, npc, the IF/ID fields and fetch_count.

## Timing
- imem_addr is combinational from pc with zero cycles of latency. imem_data is sampled on the same edge that advances pc.
- Fetch to IF/ID latency: instruction at address A appears on ifid_instr one edge after pc=A is presented.
- Redirect is sampled at edge k, while the CTI is in IF/ID and the delay slot is at pc.
  - At edge k the delay slot (or NOP if annulled) enters IF/ID and pc becomes target.
  - At edge k+1 the target instruction enters IF/ID.
  - There is no further bubble.
- Back-to-back redirects on consecutive edges (CTI in a delay slot) are honoured in order. Each edge uses its own target.
- Reset released mid-stall: the first LE=1 edge after R=1 fetches address 0.
- An asynchronous reset assertion mid-cycle clears outputs immediately, without waiting for Clk.

## Test plan
- Reset: hold R=0 → pc=0, npc=4, ifid_valid=0, ifid_instr=32'h0100_0000, fetch_count=0. Release R=1 with LE=1, memory word at 0 = 32'h8200_6001 → after edge 1, ifid_instr=32'h8200_6001, ifid_pc=0, pc=4, npc=8.
- Sequential fetch: 3 edges from reset → pc=12, npc=16, ifid_pc=8, fetch_count=3. Then LE=0 for 2 edges → all values unchanged.
- Redirect: CTI at 8 in IF/ID, pc=12, redirect=1, target=8'h41 → edge: ifid_pc=12, valid=1, pc=0x40, npc=0x44. Next edge: ifid_pc=0x40.
- Annul: the redirect case repeated with annul=1 → ifid_instr=NOP_WORD, ifid_valid=0, pc=0x40, fetch_count not incremented. Annul=1 with redirect=0 at pc=12 → NOP inserted, pc=16.
- Wrap: force a fetch sequence to pc=0xF8 → successive pc values 0xFC, 0x00, 0x04.
- Reset mid-operation: after 5 edges, pulse R=0 between clock edges → all outputs return to their reset values immediately. The fetch sequence restarts at 0.
